// File: rtl/rgbled_pkg.sv
// rgbled_ctrl shared types: FSM states, colour word, GRB reorder.
package rgbled_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } rgbled_state_e;

  typedef logic [23:0] colour_t;

  function automatic colour_t rgb_to_grb(colour_t c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

endpackage

// File: rtl/rgbled_ctrl_if.sv
// Word stream between rgbled_ctrl and the ws281x driver.
interface rgbled_ctrl_if;
  import rgbled_pkg::*;

  logic    go_o;
  colour_t data_o;
  logic    data_valid_o;
  logic    data_last_o;
  logic    data_ack_i;
  logic    idle_i;

  modport master (
    output go_o,
    output data_o,
    output data_valid_o,
    output data_last_o,
    input  data_ack_i,
    input  idle_i
  );

  modport slave (
    input  go_o,
    input  data_o,
    input  data_valid_o,
    input  data_last_o,
    output data_ack_i,
    output idle_i
  );

endinterface

// File: rtl/rgbled_ctrl.sv
// Per-LED colour frame sequencer feeding ws281x_drv:
// shadow/active colour sets, word streaming, latch gap.
module rgbled_ctrl
  import rgbled_pkg::*;
#(
  parameter int NumLeds = 2,
  parameter int ClkFreq = 25_000_000,
  parameter int LatchUs = 80,
  localparam int IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            colour_we_i,
  input  logic [IdxW-1:0] colour_idx_i,
  input  colour_t         colour_i,
  input  logic            en_i,
  input  logic            update_i,
  output logic            busy_o,
  rgbled_ctrl_if.master   drv
);

  localparam int LatchCycles = ClkFreq / 1_000_000 * LatchUs;
  localparam int CntW = $clog2(LatchCycles + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);
  localparam logic [CntW-1:0] CntTop = CntW'(LatchCycles - 1);

  rgbled_state_e   state_q, state_d;
  colour_t         shadow_q [NumLeds];
  colour_t         active_q [NumLeds];
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic            is_last;
  logic            gap_done;
  logic            in_send;

  assign is_last  = (idx_q == LastIdx);
  assign gap_done = drv.idle_i && (cnt_q == CntTop);
  assign in_send  = (state_q == SEND);

  // Outputs decode from state and registers only; ack never reaches them.
  assign busy_o           = (state_q != IDLE);
  assign drv.go_o         = in_send;
  assign drv.data_valid_o = in_send;
  assign drv.data_last_o  = in_send && is_last;
  assign drv.data_o       = in_send ? rgb_to_grb(active_q[idx_q]) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (update_i || pending_q) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: if (drv.data_ack_i && is_last) state_d = GAP;
      GAP:  if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < NumLeds; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (colour_we_i && (int'(colour_idx_i) < NumLeds))
        shadow_q[colour_idx_i] <= colour_i;

      // IDLE always consumes a pending request on its way to LOAD.
      if (state_q == IDLE)  pending_q <= 1'b0;
      else if (update_i)    pending_q <= 1'b1;

      unique case (state_q)
        LOAD: begin
          idx_q <= '0;
          for (int k = 0; k < NumLeds; k++)
            active_q[k] <= en_i ? shadow_q[k] : '0;
        end
        SEND: begin
          if (drv.data_ack_i && !is_last) idx_q <= idx_q + 1'b1;
        end
        GAP: begin
          if (!drv.idle_i || gap_done) cnt_q <= '0;
          else                         cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
